mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared shift-and-select datapath in the mux tree. Up to NUM_REQ requesters compete for one shared output channel. The block grants one requester at a time and captures its operand. It applies the fixed left-shift calculation and presents the result on a valid/ready output port. It replaces static `sel` wiring wherever more than one source needs the shared mux/calc path.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, operand and result width
- SHIFT, 3, left-shift amount applied to the granted operand (the calc stage's `in << 2 + 1`)
- IDX_W, $clog2(NUM_REQ), width of `out_src` (localparam)

- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request; held high until that requester's `ack` pulse
- req_data  in  NUM_REQ*DATA_W  operands; requester k occupies bits [k*DATA_W +: DATA_W]; stable while req[k] is high
- ack  out  NUM_REQ  one-hot, one-cycle pulse: the operand of requester k was captured
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  computed result
- out_src  out  IDX_W  index of the requester that produced `out_data`
- busy  out  1  high whenever `out_valid` is high or any req bit is high

## Operation
- The FSM has two states: IDLE (no result held) and VALID (result held in the output register).
- Eligible set: `req & ~ack`. The requester acked in the current cycle is masked, so a req still high during its own ack cycle is never granted twice.
- Arbitration picks the first eligible index at or after `ptr`, searching upward with wrap from NUM_REQ-1 to 0. `ptr` resets to 0. After each grant k, `ptr` becomes (k+1) mod NUM_REQ.
- A capture sets `out_data = (req_data[k] << SHIFT)[DATA_W-1:0]`. The result is zero-filled from the LSB and truncated at the MSB; no saturation. A capture also sets `out_src = k`, `ack[k] = 1` for one cycle, and `out_valid = 1`.
- IDLE -> VALID: any eligible req triggers a capture.
- VALID with `out_ready = 0`: hold. `out_data` and `out_src` stay frozen, no ack is issued, and `ptr` is unchanged.
- VALID with `out_ready = 1`:
  - If an eligible req exists, capture it in the same edge and stay in VALID (back-to-back transfer).
  - Otherwise clear `out_valid` and go to IDLE.
- `out_ready` is ignored in IDLE.
- `ack` is zero in every cycle without a capture, so at most one bit is ever set.
- Reset values: state IDLE, `ptr` 0, `ack` 0, `out_valid` 0, `out_data` 0, `out_src` 0. `busy` is combinational and follows req.
- Reset mid-transfer discards the held result immediately. Requesters that were not yet acked keep req high and are arbitrated after reset release.

## Timing
- Capture edge E: `ack[k]`, `out_valid`, `out_data`, and `out_src` all update at E.
- Latency: 1 cycle from req sampled high (while IDLE) to `out_valid` high.
- Throughput: 1 result per cycle while `out_ready` is held high and eligible requests are present.
- A requester sees `ack[k]` in the cycle after E. It must drop req, or present new data with req still high, by the next edge. Because of the ack mask, a held req can be regranted no earlier than 2 cycles after its previous capture edge.
- `out_valid` never drops without a handshake, except on reset. `out_data` and `out_src` stay stable while `out_valid && !out_ready`.
- `busy` is the only combinational output. All others are registered.

## Test plan
- Single requester: req[2] is high with data 0x05 and `out_ready = 1`.
  - Next cycle: `ack = 4'b0100`, `out_valid = 1`, `out_data = 0x28`, `out_src = 2`.
  - One cycle later: `out_valid = 0`.
- Fairness: req = 4'b1111 held high and `out_ready = 1`. Grants occur in the order 0, 1, 2, 3, 0, … Each requester is granted at most once per four grants, and each ack is one-hot.
- Backpressure: `out_ready = 0` for 5 cycles after a capture.
  - `out_valid`, `out_data`, and `out_src` stay constant, and no further ack is issued.
  - In the cycle `out_ready` rises with req[1] pending, req[1] is captured at that edge and acked.
- Truncation: data 0x25 with SHIFT = 3 gives `out_data = 0x28`. Data 0xFF gives 0xF8.
- Reset mid-operation: assert rst while `out_valid = 1` and `out_ready = 0`.
  - All outputs go to 0 asynchronously, with no clock edge needed.
  - After release, a still-high req[3] is granted first, giving `out_src = 3` one cycle later.
- Wrap and mask: after a grant to index 3, with req = 4'b1001 both high, the next grant goes to 0, not 3.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding the shared shift-and-select path: grants one requester,
// captures (operand << SHIFT) into a registered valid/ready output, one result per cycle.
module mux_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  parameter  int SHIFT   = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_src,
  output logic                       busy
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [DATA_W-1:0]  operand;
  logic               capture;
  int                 pos;

  // A requester acked this cycle may still hold req high; masking it prevents a double grant.
  assign eligible = req & ~ack;

  // Scan from the highest offset down so the last hit is the closest index at or after ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (eligible[pos]) begin
        grant_vld = 1'b1;
        grant_idx = pos[IDX_W-1:0];
      end
    end
  end

  assign operand  = req_data[grant_idx*DATA_W +: DATA_W];
  assign ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign capture  = grant_vld && ((state == IDLE) || out_ready);
  assign busy     = out_valid || (|req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      ack <= '0;
      if (capture) begin
        state     <= VALID;
        out_valid <= 1'b1;
        out_data  <= operand << SHIFT;
        out_src   <= grant_idx;
        ack       <= NUM_REQ'(1) << grant_idx;
        ptr       <= ptr_next;
      end else if ((state == VALID) && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: vector table plus fairness, backpressure and reset sequences.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .SHIFT(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] rdata;
    logic        rdy;
    logic [3:0]  ack;
    logic        vld;
    logic [7:0]  dat;
    logic [1:0]  src;
    logic        busy;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eack, input logic evld,
                         input logic [7:0] edat, input logic [1:0] esrc);
    chk({tag, ".ack"}, ack, eack);
    chk({tag, ".valid"}, out_valid, evld);
    if (evld) begin
      chk({tag, ".data"}, out_data, edat);
      chk({tag, ".src"}, out_src, esrc);
    end
  endtask

  initial begin
    // req[2]=05 single grant; idle drop; wrap 3 then 0 with mask; truncation 25->28, FF->F8; hold; drain
    tbl[0] = '{4'b0100, 32'h0005_0000, 1'b1, 4'b0100, 1'b1, 8'h28, 2'd2, 1'b1};
    tbl[1] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2] = '{4'b1000, 32'h2500_0000, 1'b1, 4'b1000, 1'b1, 8'h28, 2'd3, 1'b1};
    tbl[3] = '{4'b1001, 32'h2500_00FF, 1'b1, 4'b0001, 1'b1, 8'hF8, 2'd0, 1'b1};
    tbl[4] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'hF8, 2'd0, 1'b1};
    tbl[5] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};

    rst = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;
    #2;
    chk_out("reset", 4'b0000, 1'b0, 8'h00, 2'd0);
    chk("reset.data", out_data, 8'h00);
    chk("reset.src", out_src, 2'd0);
    chk("reset.busy", busy, 1'b0);
    step();
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      req = tbl[v].req; req_data = tbl[v].rdata; out_ready = tbl[v].rdy;
      step();
      chk_out($sformatf("vec%0d", v), tbl[v].ack, tbl[v].vld, tbl[v].dat, tbl[v].src);
      chk($sformatf("vec%0d.busy", v), busy, tbl[v].busy);
    end

    // Fairness from a fresh pointer: all four held high, ready high.
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b1111; req_data = 32'h0403_0201; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("fair%0d", i), 4'b0001 << (i % 4), 1'b1,
              8'((i % 4 + 1) << 3), 2'(i % 4));
    end
    req = 4'b0000;
    step();
    chk("fair.drain", out_valid, 1'b0);

    // Backpressure: capture req0 with ready low (ignored in idle), then hold 5 cycles.
    req = 4'b0001; req_data = 32'h0000_0011; out_ready = 1'b0;
    step();
    chk_out("bp.cap", 4'b0001, 1'b1, 8'h88, 2'd0);
    req = 4'b0010; req_data = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp.hold%0d", i), 4'b0000, 1'b1, 8'h88, 2'd0);
    end
    out_ready = 1'b1;
    step();
    chk_out("bp.release", 4'b0010, 1'b1, 8'h10, 2'd1);
    req = 4'b0000;
    step();
    chk("bp.drain", out_valid, 1'b0);

    // Reset while holding a result; req[3] pending must win first after release.
    req = 4'b0001; req_data = 32'h0300_0001; out_ready = 1'b0;
    step();
    chk_out("rst.cap", 4'b0001, 1'b1, 8'h08, 2'd0);
    req = 4'b1000;
    step();
    chk("rst.held", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_out("rst.async", 4'b0000, 1'b0, 8'h00, 2'd0);
    chk("rst.async.data", out_data, 8'h00);
    chk("rst.async.src", out_src, 2'd0);
    chk("rst.async.busy", busy, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk_out("rst.after", 4'b1000, 1'b1, 8'h18, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
